// File: rtl/cpu_pkg.sv
// cpu_pkg: shared T-state, opcode group, addressing-mode and instruction-class definitions
package cpu_pkg;
  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} t_state_e;
  typedef enum logic [1:0] {IMPL, READ, STORE, RMW} op_class_e;
  localparam logic [2:0] INX = 3'd0, ZPG = 3'd1, IMM = 3'd2, ABS = 3'd3;
  localparam logic [2:0] INY = 3'd4, ZPX = 3'd5, ABY = 3'd6, ABX = 3'd7;
  localparam logic [4:0] G_ORA = 5'b000_01, G_AND = 5'b001_01, G_EOR = 5'b010_01, G_ADC = 5'b011_01;
  localparam logic [4:0] G_STA = 5'b100_01, G_LDA = 5'b101_01, G_CMP = 5'b110_01, G_SBC = 5'b111_01;
  localparam logic [4:0] G_ASL = 5'b000_10, G_ROL = 5'b001_10, G_LSR = 5'b010_10, G_ROR = 5'b011_10;
  localparam logic [4:0] G_STX = 5'b100_10, G_LDX = 5'b101_10, G_DEC = 5'b110_10, G_INC = 5'b111_10;
  localparam logic [4:0] G_BIT = 5'b001_00, G_JMP = 5'b010_00, G_STY = 5'b100_00, G_LDY = 5'b101_00;
  localparam logic [4:0] G_CPY = 5'b110_00, G_CPX = 5'b111_00;
  localparam logic [7:0] OP_CLC = 8'h18, OP_CLD = 8'hD8, OP_CLI = 8'h58, OP_CLV = 8'hB8;
  localparam logic [7:0] OP_DEX = 8'hCA, OP_DEY = 8'h88, OP_INX = 8'hE8, OP_INY = 8'hC8;
  localparam logic [7:0] OP_NOP = 8'hEA, OP_SEC = 8'h38, OP_SED = 8'hF8, OP_SEI = 8'h78;
  localparam logic [7:0] OP_TAX = 8'hAA, OP_TAY = 8'hA8, OP_TSX = 8'hBA, OP_TXA = 8'h8A;
  localparam logic [7:0] OP_TXS = 8'h9A, OP_TYA = 8'h98;
  function automatic logic is_implied(input logic [7:0] op);
    return op inside {OP_CLC, OP_CLD, OP_CLI, OP_CLV, OP_DEX, OP_DEY, OP_INX, OP_INY, OP_NOP,
                      OP_SEC, OP_SED, OP_SEI, OP_TAX, OP_TAY, OP_TSX, OP_TXA, OP_TXS, OP_TYA};
  endfunction
endpackage

// File: rtl/op_classify.sv
// op_classify: maps the instruction register to its timing class and bbb addressing mode
module op_classify import cpu_pkg::*; #(
  parameter bit RMW_EN = 1'b1
) (
  input  logic [7:0] ir,
  output op_class_e  cls,
  output logic [2:0] mode
);
  logic [4:0] grp;
  logic st, rm;
  assign grp = {ir[7:5], ir[1:0]};
  assign mode = ir[4:2];
  assign st = (grp == G_STA && mode != IMM) ||
              ((grp == G_STX || grp == G_STY) && (mode == ZPG || mode == ABS || mode == ZPX));
  // memory modes of the shift/inc/dec group all have an odd bbb
  assign rm = RMW_EN && mode[0] && grp inside {G_ASL, G_ROL, G_LSR, G_ROR, G_DEC, G_INC};
  assign cls = is_implied(ir) ? IMPL : st ? STORE : rm ? RMW : READ;
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: steps T0-T6 per instruction class and drives sync/last/pc_inc/we
module cycle_sequencer import cpu_pkg::*; #(
  parameter bit         PAGE_PENALTY = 1'b1,
  parameter bit         RMW_EN       = 1'b1,
  parameter logic [7:0] RESET_OP     = 8'hEA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] d_in,
  input  logic       page_cross,
  output logic [7:0] ir,
  output logic [2:0] state,
  output logic       sync,
  output logic       last,
  output logic       pc_inc,
  output logic       we
);
  op_class_e  cls;
  logic [2:0] mode, n, nxt;
  logic       pen;
  op_classify #(.RMW_EN(RMW_EN)) u_classify (.ir(ir), .cls(cls), .mode(mode));
  assign n = (cls == IMPL || mode == IMM) ? 3'd2 :
             mode == ZPG ? (cls == RMW ? 3'd5 : 3'd3) :
             (mode == ZPX || mode == ABS) ? (cls == RMW ? 3'd6 : 3'd4) :
             mode == ABX ? (cls == RMW ? 3'd7 : cls == STORE ? 3'd5 : 3'd4) :
             mode == ABY ? (cls == STORE ? 3'd5 : 3'd4) :
             mode == INX ? 3'd6 : (cls == STORE ? 3'd6 : 3'd5);
  // indexed reads may stretch by one cycle, decided in their nominal last cycle
  assign pen = PAGE_PENALTY && cls == READ && (mode == ABX || mode == ABY || mode == INY);
  assign last = (state == n - 3'd1 && !(pen && page_cross)) || (pen && state == n);
  assign sync = state == T0;
  assign pc_inc = rdy && (sync || (state == T1 && cls != IMPL) ||
                  (state == T2 && (mode == ABS || mode == ABX || mode == ABY)));
  assign we = (cls == STORE && state == n - 3'd1) ||
              (cls == RMW && (state == n - 3'd1 || state == n - 3'd2));
  assign nxt = (last || state > T6) ? T0 : state + 3'd1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= T0;
      ir <= RESET_OP;
    end else if (rdy) begin
      state <= nxt;
      if (sync) ir <= d_in;
    end
  end
endmodule
